// File: rtl/sd_spi_host.sv
`default_nettype none
// ============================================================================
// sd_spi_host : SPI-mode SD host running single-block CMD17 reads / CMD24 writes
// Rev 1.0
// ============================================================================
module sd_spi_host #(
  parameter int CLK_DIV       = 2,
  parameter int R1_POLL       = 8,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic        cmd_wr,
  input  logic [31:0] lba,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err,
  output logic [8:0]  buff_addr,
  output logic [7:0]  buff_dout,
  output logic        buff_wr,
  input  logic [7:0]  buff_din,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        ss
);
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);
  localparam logic [12:0]      c_r1_last  = 13'(R1_POLL - 1);
  localparam logic [12:0]      c_tok_last = 13'(TOKEN_TIMEOUT - 1);

  localparam logic [3:0] c_st_idle   = 4'd0;
  localparam logic [3:0] c_st_cmd    = 4'd1;
  localparam logic [3:0] c_st_r1     = 4'd2;
  localparam logic [3:0] c_st_rtoken = 4'd3;
  localparam logic [3:0] c_st_rdata  = 4'd4;
  localparam logic [3:0] c_st_rcrc   = 4'd5;
  localparam logic [3:0] c_st_wgap   = 4'd6;
  localparam logic [3:0] c_st_wtoken = 4'd7;
  localparam logic [3:0] c_st_wdata  = 4'd8;
  localparam logic [3:0] c_st_wcrc   = 4'd9;
  localparam logic [3:0] c_st_wresp  = 4'd10;
  localparam logic [3:0] c_st_wbusy  = 4'd11;
  localparam logic [3:0] c_st_finish = 4'd12;
  localparam logic [3:0] c_st_done   = 4'd13;

  logic [3:0]       r_state, w_state_next;
  logic             r_wr;
  logic [31:0]      r_lba;
  logic [8:0]       r_idx;
  logic [12:0]      r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit;
  logic [7:0]       r_tx, r_rx;
  logic             r_sck, r_mosi;
  logic [2:0]       r_err;
  logic [8:0]       r_buff_addr;
  logic [7:0]       r_buff_dout;
  logic             r_buff_wr;
  logic [7:0]       w_tx_next;
  logic             w_err_set;
  logic [2:0]       w_err_code;
  logic             w_run, w_byte_end, w_start_ok, w_load;

  assign w_start_ok = (r_state == c_st_idle) && start;
  assign w_run      = (r_state != c_st_idle) && (r_state != c_st_done);
  // End of the 8th high phase: next byte's low phase begins on this edge
  assign w_byte_end = w_run && r_sck && (r_div == c_div_last) && (r_bit == 3'd7);
  assign w_load     = w_start_ok || w_byte_end;

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= c_st_idle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_tx_next    = 8'hFF;
    w_err_set    = 1'b0;
    w_err_code   = 3'd0;
    case (r_state)
      c_st_idle: if (start) begin
        w_state_next = c_st_cmd;
        w_tx_next    = cmd_wr ? 8'h58 : 8'h51;
      end
      c_st_cmd: if (w_byte_end) begin
        case (r_idx[2:0])
          3'd0:    w_tx_next = r_lba[31:24];
          3'd1:    w_tx_next = r_lba[23:16];
          3'd2:    w_tx_next = r_lba[15:8];
          3'd3:    w_tx_next = r_lba[7:0];
          default: w_tx_next = 8'hFF;
        endcase
        if (r_idx[2:0] == 3'd5) w_state_next = c_st_r1;
      end
      c_st_r1: if (w_byte_end) begin
        if (!r_rx[7]) begin
          if (r_rx == 8'h00) w_state_next = r_wr ? c_st_wgap : c_st_rtoken;
          else begin w_state_next = c_st_finish; w_err_set = 1'b1; w_err_code = 3'd2; end
        end else if (r_cnt == c_r1_last) begin
          w_state_next = c_st_finish; w_err_set = 1'b1; w_err_code = 3'd1;
        end
      end
      c_st_rtoken: if (w_byte_end) begin
        if (r_rx == 8'hFE) w_state_next = c_st_rdata;
        else if (r_rx != 8'hFF || r_cnt == c_tok_last) begin
          w_state_next = c_st_finish; w_err_set = 1'b1; w_err_code = 3'd3;
        end
      end
      c_st_rdata:  if (w_byte_end && r_idx == 9'd511) w_state_next = c_st_rcrc;
      c_st_rcrc:   if (w_byte_end && r_idx[0]) w_state_next = c_st_finish;
      c_st_wgap:   if (w_byte_end) begin w_state_next = c_st_wtoken; w_tx_next = 8'hFE; end
      c_st_wtoken: if (w_byte_end) begin w_state_next = c_st_wdata; w_tx_next = buff_din; end
      c_st_wdata: if (w_byte_end) begin
        if (r_idx == 9'd511) w_state_next = c_st_wcrc;
        else                 w_tx_next = buff_din;
      end
      c_st_wcrc:   if (w_byte_end && r_idx[0]) w_state_next = c_st_wresp;
      c_st_wresp: if (w_byte_end) begin
        if ((r_rx & 8'h1F) == 8'h05) w_state_next = c_st_wbusy;
        else begin w_state_next = c_st_finish; w_err_set = 1'b1; w_err_code = 3'd4; end
      end
      c_st_wbusy: if (w_byte_end) begin
        if (r_rx == 8'hFF) w_state_next = c_st_finish;
        else if (r_cnt == c_tok_last) begin
          w_state_next = c_st_finish; w_err_set = 1'b1; w_err_code = 3'd5;
        end
      end
      c_st_finish: if (w_byte_end) w_state_next = c_st_done;
      c_st_done:   w_state_next = c_st_idle;
      default:     w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    busy = (r_state != c_st_idle);
    done = (r_state == c_st_done);
    ss   = (r_state == c_st_idle) || (r_state == c_st_finish) || (r_state == c_st_done);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wr <= 1'b0; r_lba <= '0; r_idx <= '0; r_cnt <= '0;
      r_div <= '0; r_bit <= '0; r_tx <= 8'hFF; r_rx <= '0;
      r_sck <= 1'b0; r_mosi <= 1'b1; r_err <= '0;
      r_buff_addr <= '0; r_buff_dout <= '0; r_buff_wr <= 1'b0;
    end else begin
      r_buff_wr <= 1'b0;
      if (w_start_ok) begin
        r_wr  <= cmd_wr;
        r_lba <= lba;
        r_err <= 3'd0;
      end
      if (w_err_set) r_err <= w_err_code;

      if (w_state_next != r_state) begin
        r_idx <= '0;
        r_cnt <= '0;
      end else if (w_byte_end) begin
        r_idx <= r_idx + 9'd1;
        r_cnt <= r_cnt + 13'd1;
      end

      if (!w_run && !w_load) begin
        r_sck <= 1'b0; r_mosi <= 1'b1; r_div <= '0; r_bit <= '0;
      end else if (w_load) begin
        r_tx <= w_tx_next; r_mosi <= w_tx_next[7];
        r_sck <= 1'b0; r_div <= '0; r_bit <= '0;
      end else if (r_div == c_div_last) begin
        r_div <= '0;
        if (!r_sck) begin
          r_sck <= 1'b1;
          r_rx  <= {r_rx[6:0], miso};
        end else begin
          r_sck  <= 1'b0;
          r_bit  <= r_bit + 3'd1;
          r_tx   <= {r_tx[6:0], 1'b1};
          r_mosi <= r_tx[6];
        end
      end else begin
        r_div <= r_div + 1'b1;
      end

      // Write path: address leads the byte load so the sync RAM has data ready
      if (r_state == c_st_rdata && w_byte_end) begin
        r_buff_wr   <= 1'b1;
        r_buff_dout <= r_rx;
        r_buff_addr <= r_idx;
      end else if (w_state_next == c_st_wtoken && r_state != c_st_wtoken) begin
        r_buff_addr <= '0;
      end else if (w_byte_end && (r_state == c_st_wtoken ||
                   (r_state == c_st_wdata && r_idx != 9'd511))) begin
        r_buff_addr <= r_buff_addr + 9'd1;
      end
    end
  end

  assign err       = r_err;
  assign buff_addr = r_buff_addr;
  assign buff_dout = r_buff_dout;
  assign buff_wr   = r_buff_wr;
  assign sck       = r_sck;
  assign mosi      = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_host.sv
`default_nettype none
// tb_sd_spi_host : scoreboard bench for sd_spi_host with a behavioural SPI card.
module tb_sd_spi_host;
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset, start, cmd_wr, start_x;
  logic [31:0] lba;
  logic        busy, done, buff_wr, sck, mosi, ss;
  logic        miso = 1'b1;
  logic [2:0]  err;
  logic [8:0]  buff_addr;
  logic [7:0]  buff_dout;
  logic [7:0]  buff_din = 8'h00;

  logic        busy_1, done_1, wr_1, sck_1, mosi_1, ss_1;
  logic        busy_3, done_3, wr_3, sck_3, mosi_3, ss_3;
  logic [2:0]  err_1, err_3;
  logic [8:0]  addr_1, addr_3;
  logic [7:0]  dout_1, dout_3;

  sd_spi_host #(.CLK_DIV(2), .R1_POLL(8), .TOKEN_TIMEOUT(4096)) u_dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .cmd_wr(cmd_wr), .lba(lba),
    .busy(busy), .done(done), .err(err), .buff_addr(buff_addr), .buff_dout(buff_dout),
    .buff_wr(buff_wr), .buff_din(buff_din), .sck(sck), .mosi(mosi), .miso(miso), .ss(ss));

  sd_spi_host #(.CLK_DIV(1)) u_div1 (
    .clk_sys(clk_sys), .reset(reset), .start(start_x), .cmd_wr(1'b0), .lba(32'h0000_0042),
    .busy(busy_1), .done(done_1), .err(err_1), .buff_addr(addr_1), .buff_dout(dout_1),
    .buff_wr(wr_1), .buff_din(8'h00), .sck(sck_1), .mosi(mosi_1), .miso(1'b1), .ss(ss_1));

  sd_spi_host #(.CLK_DIV(3)) u_div3 (
    .clk_sys(clk_sys), .reset(reset), .start(start_x), .cmd_wr(1'b0), .lba(32'h0000_0042),
    .busy(busy_3), .done(done_3), .err(err_3), .buff_addr(addr_3), .buff_dout(dout_3),
    .buff_wr(wr_3), .buff_din(8'h00), .sck(sck_3), .mosi(mosi_3), .miso(1'b1), .ss(ss_3));

  // Sync-RAM source for write data: content ~addr
  always @(posedge clk_sys) buff_din <= ~buff_addr[7:0];

  int n_tests = 0, n_fail = 0;
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  card_q[$];
  logic [7:0]  exp_mosi[$];
  logic [16:0] exp_wr[$];
  int          card_nb = 0, card_bits = 0, ss_hi_rises = 0, wr_cnt = 0, done_cnt = 0;
  logic [2:0]  done_err = 3'd0;
  logic [7:0]  card_rx = 8'h00, card_tx = 8'hFF;
  logic        card_pend = 1'b0, prev_sck = 1'b0;
  logic [16:0] wr_e;

  // SPI card: shifts in MOSI on sck rise, presents next MISO bit after sck fall
  always @(posedge clk_sys) begin
    #1;
    if (ss) begin
      card_bits = 0; card_pend = 1'b0; card_tx = 8'hFF; miso = 1'b1;
      if (busy && sck && !prev_sck) ss_hi_rises++;
    end else if (sck && !prev_sck) begin
      card_rx = {card_rx[6:0], mosi};
      card_bits++;
      if (card_bits == 8) begin
        card_bits = 0; card_pend = 1'b1; card_nb++;
        if (exp_mosi.size() > 0) check_eq("mosi_byte", card_rx, exp_mosi.pop_front());
      end
    end else if (!sck && prev_sck) begin
      if (card_pend) begin
        card_pend = 1'b0;
        card_tx = 8'hFF;
        if (card_nb >= 6 && card_q.size() > 0) card_tx = card_q.pop_front();
      end else card_tx = {card_tx[6:0], 1'b1};
      miso = card_tx[7];
    end
    prev_sck = sck;
  end

  always @(posedge clk_sys) begin
    #1;
    if (buff_wr) begin
      wr_cnt++;
      if (exp_wr.size() > 0) begin
        wr_e = exp_wr.pop_front();
        check_eq("wr_addr", buff_addr, wr_e[16:8]);
        check_eq("wr_data", buff_dout, wr_e[7:0]);
      end
    end
    if (done) begin done_cnt++; done_err = err; end
  end

  // SCK phase-length monitor for the CLK_DIV=1 / CLK_DIV=3 instances
  logic [1:0] ax_sck, ax_ss, ax_psck = 2'b00, ax_pss = 2'b11;
  int ax_run[2] = '{1, 1}, ax_min[2] = '{1000, 1000}, ax_max[2] = '{0, 0};
  always @(posedge clk_sys) begin
    #1;
    ax_sck = {sck_3, sck_1};
    ax_ss  = {ss_3, ss_1};
    for (int i = 0; i < 2; i++) begin
      if (ax_pss[i] == 1'b0) begin
        if (ax_sck[i] != ax_psck[i]) begin
          if (ax_run[i] < ax_min[i]) ax_min[i] = ax_run[i];
          if (ax_run[i] > ax_max[i]) ax_max[i] = ax_run[i];
          ax_run[i] = 1;
        end else ax_run[i]++;
      end else ax_run[i] = 1;
    end
    ax_psck = ax_sck;
    ax_pss  = ax_ss;
  end

  task automatic new_txn();
    card_nb = 0; wr_cnt = 0; ss_hi_rises = 0;
    card_q.delete(); exp_mosi.delete(); exp_wr.delete();
  endtask

  task automatic push_cmd(input logic wr, input logic [31:0] a);
    exp_mosi.push_back(wr ? 8'h58 : 8'h51);
    exp_mosi.push_back(a[31:24]); exp_mosi.push_back(a[23:16]);
    exp_mosi.push_back(a[15:8]);  exp_mosi.push_back(a[7:0]);
    exp_mosi.push_back(8'hFF);
  endtask

  task automatic push_ff(input int n);
    for (int i = 0; i < n; i++) exp_mosi.push_back(8'hFF);
  endtask

  task automatic card_read_stream();
    card_q.push_back(8'hFF); card_q.push_back(8'hFF); card_q.push_back(8'h00);
    for (int i = 0; i < 3; i++) card_q.push_back(8'hFF);
    card_q.push_back(8'hFE);
    for (int i = 0; i < 512; i++) begin
      card_q.push_back(8'(i) ^ 8'h5A);
      exp_wr.push_back({9'(i), 8'(i) ^ 8'h5A});
    end
    card_q.push_back(8'hFF); card_q.push_back(8'hFF);
  endtask

  task automatic card_write_stream(input logic [7:0] resp);
    card_q.push_back(8'hFF); card_q.push_back(8'hFF); card_q.push_back(8'h00);
    for (int i = 0; i < 516; i++) card_q.push_back(8'hFF);
    card_q.push_back(resp);
  endtask

  task automatic kick(input logic wr, input logic [31:0] a);
    @(negedge clk_sys); start = 1'b1; cmd_wr = wr; lba = a;
    @(negedge clk_sys); start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin @(posedge clk_sys); #2; n++; end
    check_eq({tag, "_done_seen"}, done_cnt - d0, 1);
    @(posedge clk_sys); #2;
    check_eq({tag, "_busy_after_done"}, busy, 0);
    check_eq({tag, "_single_done"}, done_cnt - d0, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0;
    reset = 1'b1; start = 1'b0; cmd_wr = 1'b0; lba = '0; start_x = 1'b0;
    repeat (3) @(posedge clk_sys);
    #2;
    check_eq("rst_busy", busy, 0);      check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);        check_eq("rst_ss", ss, 1);
    check_eq("rst_sck", sck, 0);        check_eq("rst_mosi", mosi, 1);
    check_eq("rst_buff_wr", buff_wr, 0); check_eq("rst_buff_addr", buff_addr, 0);
    check_eq("rst_buff_dout", buff_dout, 0);
    @(negedge clk_sys); reset = 1'b0;

    // MISO stuck high: 8 R1 polls then timeout; aux instances run alongside
    new_txn(); push_cmd(1'b0, 32'h0000_0010); push_ff(8);
    @(negedge clk_sys); start = 1'b1; cmd_wr = 1'b0; lba = 32'h0000_0010; start_x = 1'b1;
    @(negedge clk_sys); start = 1'b0; start_x = 1'b0;
    wait_done("t1", 2000);
    check_eq("t1_err", done_err, 1);
    check_eq("t1_ss", ss, 1);
    check_eq("t1_bytes", card_nb, 14);
    check_eq("t1_mosi_left", exp_mosi.size(), 0);
    n = 0;
    while ((busy_1 || busy_3) && n < 3000) begin @(posedge clk_sys); #2; n++; end
    check_eq("aux_idle", {busy_3, busy_1}, 0);
    check_eq("div1_err", err_1, 1);  check_eq("div3_err", err_3, 1);
    check_eq("div1_phase_min", ax_min[0], 1); check_eq("div1_phase_max", ax_max[0], 1);
    check_eq("div3_phase_min", ax_min[1], 3); check_eq("div3_phase_max", ax_max[1], 3);
    check_eq("aux_idle_outs", {done_1, wr_1, sck_1, mosi_1, ss_1, addr_1, dout_1,
                               done_3, wr_3, sck_3, mosi_3, ss_3},
             {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});

    // Reset after the 100th read byte
    new_txn(); card_read_stream(); push_cmd(1'b0, 32'h0000_00AA);
    kick(1'b0, 32'h0000_00AA);
    n = 0;
    while (wr_cnt < 100 && n < 8000) begin @(posedge clk_sys); #2; n++; end
    check_eq("abort_wr_cnt", wr_cnt, 100);
    d0 = done_cnt;
    reset = 1'b1;
    @(posedge clk_sys); #2;
    check_eq("abort_ss", ss, 1);     check_eq("abort_sck", sck, 0);
    check_eq("abort_mosi", mosi, 1); check_eq("abort_busy", busy, 0);
    check_eq("abort_buff_wr", buff_wr, 0);
    reset = 1'b0;
    repeat (200) @(posedge clk_sys); #2;
    check_eq("abort_no_done", done_cnt - d0, 0);
    check_eq("abort_still_idle", busy, 0);

    // Fresh full read
    new_txn(); card_read_stream(); push_cmd(1'b0, 32'h0000_1234); push_ff(521);
    kick(1'b0, 32'h0000_1234);
    wait_done("rd", 30000);
    check_eq("rd_err", done_err, 0);
    check_eq("rd_bytes", card_nb, 527);
    check_eq("rd_wr_cnt", wr_cnt, 512);
    check_eq("rd_wr_left", exp_wr.size(), 0);
    check_eq("rd_mosi_left", exp_mosi.size(), 0);
    check_eq("rd_trailing_clocks", ss_hi_rises, 8);

    // Read with R1 error
    new_txn();
    card_q.push_back(8'hFF); card_q.push_back(8'hFF); card_q.push_back(8'h04);
    push_cmd(1'b0, 32'h0000_0003); push_ff(3);
    kick(1'b0, 32'h0000_0003);
    wait_done("r1e", 2000);
    check_eq("r1e_err", done_err, 2);
    check_eq("r1e_wr_cnt", wr_cnt, 0);
    check_eq("r1e_bytes", card_nb, 9);
    check_eq("r1e_mosi_left", exp_mosi.size(), 0);

    // Write lba=7 with a start pulse while busy (must be ignored)
    new_txn();
    card_q.push_back(8'hFF); card_q.push_back(8'hFF); card_q.push_back(8'h00);
    for (int i = 0; i < 516; i++) card_q.push_back(8'hFF);
    card_q.push_back(8'hE5);
    for (int i = 0; i < 4; i++) card_q.push_back(8'h00);
    card_q.push_back(8'hFF);
    push_cmd(1'b1, 32'h0000_0007); push_ff(3);
    exp_mosi.push_back(8'hFF); exp_mosi.push_back(8'hFE);
    for (int i = 0; i < 512; i++) exp_mosi.push_back(~8'(i));
    push_ff(2 + 1 + 5);
    kick(1'b1, 32'h0000_0007);
    repeat (40) @(posedge clk_sys);
    kick(1'b0, 32'hDEAD_BEEF);
    wait_done("wr", 30000);
    check_eq("wr_err", done_err, 0);
    check_eq("wr_bytes", card_nb, 531);
    check_eq("wr_mosi_left", exp_mosi.size(), 0);
    check_eq("wr_no_buff_wr", wr_cnt, 0);
    check_eq("wr_addr_wrapped", buff_addr, 0);

    // Write rejected by data response 0x0B
    new_txn(); card_write_stream(8'h0B); push_cmd(1'b1, 32'h0000_0055);
    kick(1'b1, 32'h0000_0055);
    wait_done("wrej", 30000);
    check_eq("wrej_err", done_err, 4);
    check_eq("wrej_err_held", err, 4);
    check_eq("wrej_bytes", card_nb, 526);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
